// File: rtl/coa_enc_pkg.sv
// Shared definitions for the serial 8-to-3 encoder.
// Holds the request/code widths and the controller state enumeration
// used by serial_encoder_8to3 and its priority-encoder helper.
package coa_enc_pkg;

  localparam int NREQ   = 8;
  localparam int CODE_W = 3;

  // IDLE accepts a new request vector; EMIT drains it one code at a time.
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-bit priority encoder.
// Ports:
//   vec_i    : input vector, bit 7 has highest priority
//   idx_o    : index of the highest set bit (0 when vec_i is zero)
//   any_o    : at least one bit of vec_i is set
//   single_o : exactly one bit of vec_i is set
module prio_enc8
  import coa_enc_pkg::*;
(
  input  logic [NREQ-1:0]   vec_i,
  output logic [CODE_W-1:0] idx_o,
  output logic              any_o,
  output logic              single_o
);

  // Ascending scan so the highest set bit is the last (and winning) write.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (vec_i[i]) begin
        idx_o = CODE_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero only when one bit was set.
  always_comb begin
    any_o    = |vec_i;
    single_o = any_o && ((vec_i & (vec_i - NREQ'(1))) == '0);
  end

endmodule

// File: rtl/serial_encoder_8to3.sv
// Serial 8-to-3 encoder.
// Accepts an 8-bit request vector and emits the index of every set bit,
// highest first, one per code handshake.  An all-zero vector produces a
// one-cycle 'none' pulse instead of any code.
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst_n      : synchronous active-low reset
//   req        : request vector, bit i requests code i
//   req_valid  : req is presented
//   req_ready  : block can accept a new vector (high in IDLE)
//   code       : index of the currently emitted request bit (0 when idle)
//   code_valid : code is valid
//   code_ready : downstream accepts code
//   code_last  : current code is the final one of the accepted vector
//   none       : one-cycle pulse, the accepted vector was all-zero
module serial_encoder_8to3 #(
  parameter int NREQ   = 8,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              code_last,
  output logic              none
);

  import coa_enc_pkg::*;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   pending_q, pending_d;
  logic              none_q, none_d;

  logic [CODE_W-1:0] topIdx;
  logic              anySet;
  logic              singleSet;

  // The priority encoder always looks at the registered pending vector, so
  // every output below is a function of flops only.
  prio_enc8 u_prio (
    .vec_i    (pending_q),
    .idx_o    (topIdx),
    .any_o    (anySet),
    .single_o (singleSet)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a nonzero vector starts emission, the handshake on the
  // last remaining bit returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && (|req)) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (code_ready && singleSet) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending vector and none-pulse update.  In IDLE the vector is latched
  // as-is (a zero vector leaves pending empty and raises none); in EMIT each
  // accepted code knocks out the bit it reported.  req is ignored in EMIT.
  always_comb begin
    pending_d = pending_q;
    none_d    = 1'b0;
    if (state_q == IDLE) begin
      if (req_valid) begin
        pending_d = req;
        none_d    = ~(|req);
      end
    end else if (code_ready) begin
      pending_d = pending_q & ~(NREQ'(1) << topIdx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      none_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      none_q    <= none_d;
    end
  end

  // Output decode from registered state; code is forced to zero when idle.
  always_comb begin
    req_ready  = (state_q == IDLE);
    code_valid = (state_q == EMIT) && anySet;
    code       = code_valid ? topIdx : '0;
    code_last  = code_valid && singleSet;
    none       = none_q;
  end

endmodule

// File: tb/tb_serial_encoder_8to3.sv
// Testbench for serial_encoder_8to3.
// A queue-based reference model holds the list of codes still owed for the
// accepted vector; expected outputs are derived from that list each cycle.
module tb_serial_encoder_8to3;

  logic       clk;
  logic       rstN;
  logic [7:0] req;
  logic       reqValid;
  logic       reqReady;
  logic [2:0] code;
  logic       codeValid;
  logic       codeReady;
  logic       codeLast;
  logic       none;

  int checks;
  int errors;

  // Reference model: remaining codes in emission order and the none pulse.
  int expCodes[$];
  bit expNone;

  serial_encoder_8to3 #(
    .NREQ   (8),
    .CODE_W (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .req        (req),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .code       (code),
    .code_valid (codeValid),
    .code_ready (codeReady),
    .code_last  (codeLast),
    .none       (none)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point; counts and reports any mismatch.
  task automatic checkOne(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Compare every output against what the model currently owes.
  task automatic checkOutput(input string tag);
    int expValid;
    int expCode;
    int expLast;
    expValid = (expCodes.size() > 0) ? 1 : 0;
    expCode  = expValid ? expCodes[0] : 0;
    expLast  = (expCodes.size() == 1) ? 1 : 0;
    checkOne({tag, ".code_valid"}, int'(codeValid), expValid);
    checkOne({tag, ".code"},       int'(code),      expCode);
    checkOne({tag, ".code_last"},  int'(codeLast),  expLast);
    checkOne({tag, ".req_ready"},  int'(reqReady),  (expCodes.size() == 0) ? 1 : 0);
    checkOne({tag, ".none"},       int'(none),      int'(expNone));
  endtask

  // Advance the model across one rising edge using the inputs being driven.
  task automatic modelEdge(input logic r, input logic v, input logic [7:0] vec, input logic cr);
    bit newNone;
    newNone = 1'b0;
    if (!r) begin
      expCodes.delete();
    end else if (expCodes.size() == 0) begin
      if (v) begin
        if (vec == 8'h00) begin
          newNone = 1'b1;
        end else begin
          for (int b = 7; b >= 0; b--) begin
            if (vec[b]) expCodes.push_back(b);
          end
        end
      end
    end else if (cr) begin
      void'(expCodes.pop_front());
    end
    expNone = newNone;
  endtask

  // Drive one cycle of inputs, check outputs, then clock and update model.
  task automatic applyStimulus(input string tag, input logic r, input logic v,
                               input logic [7:0] vec, input logic cr);
    rstN      = r;
    reqValid  = v;
    req       = vec;
    codeReady = cr;
    checkOutput(tag);
    @(posedge clk);
    modelEdge(r, v, vec, cr);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    expNone   = 1'b0;
    rstN      = 1'b0;
    reqValid  = 1'b1;
    req       = 8'hFF;
    codeReady = 1'b1;

    // Reset with req_valid asserted; it must be ignored.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    applyStimulus("reset_hold", 1'b0, 1'b1, 8'h3C, 1'b1);

    // Single top bit.
    applyStimulus("single_acc", 1'b1, 1'b1, 8'h80, 1'b1);
    repeat (3) applyStimulus("single_emit", 1'b1, 1'b0, 8'h00, 1'b1);

    // Four codes 7,5,2,0 back to back.
    applyStimulus("a5_acc", 1'b1, 1'b1, 8'hA5, 1'b1);
    repeat (5) applyStimulus("a5_emit", 1'b1, 1'b0, 8'h00, 1'b1);

    // All-zero vector raises none only.
    applyStimulus("zero_acc", 1'b1, 1'b1, 8'h00, 1'b1);
    repeat (3) applyStimulus("zero_after", 1'b1, 1'b0, 8'h00, 1'b1);

    // Backpressure holds code 2 stable.
    applyStimulus("bp_acc", 1'b1, 1'b1, 8'h06, 1'b0);
    repeat (3) applyStimulus("bp_hold", 1'b1, 1'b0, 8'h00, 1'b0);
    repeat (3) applyStimulus("bp_drain", 1'b1, 1'b0, 8'h00, 1'b1);

    // Reset mid-emission discards the rest of 8'hFF.
    applyStimulus("ff_acc", 1'b1, 1'b1, 8'hFF, 1'b1);
    repeat (2) applyStimulus("ff_emit", 1'b1, 1'b0, 8'h00, 1'b1);
    applyStimulus("ff_rst", 1'b0, 1'b0, 8'h00, 1'b1);
    repeat (3) applyStimulus("ff_after", 1'b1, 1'b0, 8'h00, 1'b1);

    // New request during EMIT is ignored.
    applyStimulus("busy_acc", 1'b1, 1'b1, 8'h81, 1'b0);
    applyStimulus("busy_new", 1'b1, 1'b1, 8'h01, 1'b0);
    applyStimulus("busy_new2", 1'b1, 1'b1, 8'h01, 1'b1);
    applyStimulus("busy_last", 1'b1, 1'b0, 8'h01, 1'b1);
    repeat (2) applyStimulus("busy_after", 1'b1, 1'b0, 8'h00, 1'b1);

    // Randomized traffic with occasional zero vectors and resets.
    for (int n = 0; n < 600; n++) begin
      logic       r;
      logic       v;
      logic       cr;
      logic [7:0] vec;
      r   = ($urandom_range(0, 60) != 0);
      v   = ($urandom_range(0, 2) != 0);
      cr  = ($urandom_range(0, 9) < 7);
      vec = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      applyStimulus("rand", r, v, vec, cr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
